// File: rtl/regfile_pkg.sv
// Shared constants and types for the 2-read / 1-write architectural register file.
package regfile_pkg;

  localparam int unsigned RF_WIDTH    = 32;
  localparam int unsigned RF_DEPTH    = 32;
  localparam int unsigned RF_AW       = 5;
  localparam int unsigned RF_ZERO_REG = 0;

  typedef logic [RF_AW-1:0]    rf_addr_t;
  typedef logic [RF_WIDTH-1:0] rf_data_t;

endpackage

// File: rtl/reg_cell_fall.sv
// Single register captured on the falling clock edge, with write enable and
// asynchronous active-high clear.
module reg_cell_fall #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] q_d, q_q;

  always_comb begin
    q_d = q_q;
    if (en_i) q_d = d_i;
  end

  always_ff @(negedge clk_i or posedge clr_i) begin
    if (clr_i) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/regfile_2r1w.sv
// Architectural register file: DEPTH x WIDTH, one falling-edge write port, two
// combinational read ports, r0 hardwired to zero. Define REGFILE_BYPASS_EN to
// forward write data to a matching read port for the whole cycle.
module regfile_2r1w
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH = RF_WIDTH,
  parameter int unsigned DEPTH = RF_DEPTH,
  parameter int unsigned AW    = RF_AW
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ctrl_writeEnable,
  input  logic [AW-1:0]    ctrl_writeReg,
  input  logic [WIDTH-1:0] data_writeReg,
  input  logic [AW-1:0]    ctrl_readRegA,
  input  logic [AW-1:0]    ctrl_readRegB,
  output logic [WIDTH-1:0] data_readRegA,
  output logic [WIDTH-1:0] data_readRegB
);

  logic [WIDTH-1:0] regs [DEPTH];
  logic             wr_valid;

  assign wr_valid = ctrl_writeEnable && (ctrl_writeReg != AW'(RF_ZERO_REG));

  // No cell exists for r0, so writes to it vanish and it always reads zero.
  assign regs[0] = '0;

  for (genvar i = 1; i < DEPTH; i++) begin : g_cell
    reg_cell_fall #(
      .Width (WIDTH)
    ) u_cell (
      .clk_i (clk),
      .clr_i (clr),
      .en_i  (wr_valid && (ctrl_writeReg == AW'(i))),
      .d_i   (data_writeReg),
      .q_o   (regs[i])
    );
  end

  always_comb begin
    data_readRegA = regs[ctrl_readRegA];
    data_readRegB = regs[ctrl_readRegB];
`ifdef REGFILE_BYPASS_EN
    if (!clr && wr_valid && (ctrl_readRegA == ctrl_writeReg)) data_readRegA = data_writeReg;
    if (!clr && wr_valid && (ctrl_readRegB == ctrl_writeReg)) data_readRegB = data_writeReg;
`endif
  end

endmodule

// File: tb/tb_regfile_2r1w.sv
// Scoreboard bench for regfile_2r1w: stimulus queues expected read data, a
// monitor samples both read ports on each sample event and compares.
module tb_regfile_2r1w;
  import regfile_pkg::*;

  logic     clk = 1'b0;
  logic     clr;
  logic     we;
  rf_addr_t wr_addr;
  rf_data_t wr_data;
  rf_addr_t ra, rb;
  rf_data_t rd_a, rd_b;

  int checks = 0;
  int errors = 0;

  string    name_q[$];
  rf_data_t ea_q[$];
  rf_data_t eb_q[$];
  event     sample_ev;

  regfile_2r1w dut (
    .clk              (clk),
    .clr              (clr),
    .ctrl_writeEnable (we),
    .ctrl_writeReg    (wr_addr),
    .data_writeReg    (wr_data),
    .ctrl_readRegA    (ra),
    .ctrl_readRegB    (rb),
    .data_readRegA    (rd_a),
    .data_readRegB    (rd_b)
  );

  always #10 clk = ~clk;

  // Monitor: the read ports are combinational, so a sample event is the "output valid".
  initial begin
    forever begin
      @(sample_ev);
      checks++;
      if (name_q.size() == 0) begin
        errors++;
        $display("FAIL sample_without_expectation: got A=%h B=%h", rd_a, rd_b);
      end else begin
        string    n;
        rf_data_t ea, eb;
        n  = name_q.pop_front();
        ea = ea_q.pop_front();
        eb = eb_q.pop_front();
        if (rd_a !== ea || rd_b !== eb) begin
          errors++;
          $display("FAIL %s: got A=%h B=%h, expected A=%h B=%h", n, rd_a, rd_b, ea, eb);
        end
      end
    end
  end

  task automatic expect_rd(input string n, input rf_data_t ea, input rf_data_t eb);
    #1;
    name_q.push_back(n);
    ea_q.push_back(ea);
    eb_q.push_back(eb);
    ->sample_ev;
    #1;
  endtask

  task automatic wr(input rf_addr_t a, input rf_data_t d);
    @(posedge clk);
    #1;
    we      = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(negedge clk);
    #1;
    we = 1'b0;
  endtask

  initial begin
    rf_data_t byp_first;
`ifdef REGFILE_BYPASS_EN
    byp_first = 32'h0000_0022;
`else
    byp_first = 32'h0000_0011;
`endif
    clr = 1'b1; we = 1'b0; wr_addr = '0; wr_data = '0; ra = '0; rb = '0;

    // Reset: reads zero, bypass and writes suppressed while clr is high.
    @(posedge clk); #1;
    ra = 5'd5; rb = 5'd7;
    expect_rd("reset_state", 32'h0, 32'h0);
    we = 1'b1; wr_addr = 5'd5; wr_data = 32'hAAAA_5555; ra = 5'd5; rb = 5'd5;
    expect_rd("clr_no_bypass", 32'h0, 32'h0);
    @(negedge clk); #1;
    we = 1'b0;
    expect_rd("clr_blocks_write", 32'h0, 32'h0);
    @(posedge clk); #1;
    clr = 1'b0;
    expect_rd("post_clr_r5", 32'h0, 32'h0);

    // Async clear mid-cycle after a falling-edge write.
    wr(5'd5, 32'hDEAD_BEEF);
    expect_rd("pre_clr_r5", 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    clr = 1'b1;
    expect_rd("clr_async", 32'h0, 32'h0);
    clr = 1'b0;
    expect_rd("clr_write_lost", 32'h0, 32'h0);

    // Basic write then dual read of the same address.
    wr(5'd7, 32'h1234_5678);
    @(posedge clk); #1;
    ra = 5'd7; rb = 5'd7;
    expect_rd("basic_r7", 32'h1234_5678, 32'h1234_5678);

    // r0 never written and never bypassed.
    @(posedge clk); #1;
    we = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF; ra = 5'd0; rb = 5'd0;
    expect_rd("zero_first_half", 32'h0, 32'h0);
    @(negedge clk); #1;
    we = 1'b0;
    expect_rd("zero_after_write", 32'h0, 32'h0);

    // Same-cycle read-after-write on port A.
    wr(5'd3, 32'h0000_0011);
    @(posedge clk); #1;
    ra = 5'd3; rb = 5'd7;
    expect_rd("raw_idle", 32'h0000_0011, 32'h1234_5678);
    we = 1'b1; wr_addr = 5'd3; wr_data = 32'h0000_0022;
    expect_rd("raw_first_half", byp_first, 32'h1234_5678);
    @(negedge clk); #1;
    expect_rd("raw_second_half", 32'h0000_0022, 32'h1234_5678);
    #4;
    expect_rd("raw_pre_rise", 32'h0000_0022, 32'h1234_5678);
    we = 1'b0;

    // Sweep: distinct pattern per register, then read mirrored pairs.
    for (int i = 1; i < 32; i++) wr(rf_addr_t'(i), rf_data_t'(i) * 32'h0101_0101);
    @(posedge clk); #1;
    for (int i = 0; i < 32; i++) begin
      ra = rf_addr_t'(i);
      rb = rf_addr_t'(31 - i);
      expect_rd($sformatf("sweep_%0d_%0d", i, 31 - i),
                rf_data_t'(i) * 32'h0101_0101, rf_data_t'(31 - i) * 32'h0101_0101);
    end

    #5;
    checks++;
    if (name_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", name_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
